ras_circular_stack: RTL and testbench
=====================================

Name: ras_circular_stack

Overview:
- Storage stage that feeds the return-address-stack predictor: holds the return addresses, exposes the current top-of-stack, and accepts push/pop commands from it.
- Circular LIFO with overwrite-oldest on overflow, so deep call chains never block.
- Accepts a checkpoint restore (top pointer + count) on pipeline flush, so wrong-path pushes and pops are undone.
- top is zero whenever the stack is empty; the predictor uses top != 0 as "entry available".

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- WIDTH, 32, bits per stored return address.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  pipeline stall; when high, push/pop are ignored.
- push  input  1  write data as the new top.
- pop  input  1  discard the current top.
- data  input  WIDTH  return address to push (caller PC + 8).
- flush  input  1  restore pointer state from the checkpoint inputs.
- restore_ptr  input  PTR_W  checkpointed top pointer.
- restore_count  input  PTR_W+1  checkpointed occupancy, 0..DEPTH.
- top  output  WIDTH  entry at the top pointer; 0 when count == 0.
- tos_ptr  output  PTR_W  current top pointer, captured by the pipeline as a checkpoint.
- count  output  PTR_W+1  current occupancy.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

Behaviour:
- State: mem[DEPTH] of WIDTH bits, tos_ptr register, count register.
- Reset (async, reset low):
  - all mem entries = 0; tos_ptr = DEPTH-1; count = 0.
  - Outputs while in reset: top = 0, empty = 1, full = 0.
  - Reset asserted mid-sequence discards all contents immediately, with no clock needed.
- top, empty and full are combinational from registered state; push/pop effects are visible the cycle after the edge.
- Priority at each rising edge: flush > stall > push/pop.
- flush = 1:
  - tos_ptr <= restore_ptr; count <= restore_count; mem unchanged.
  - Any simultaneous push/pop is dropped.
  - Overrides stall.
- stall = 1 with flush = 0: no state change.
- push only:
  - tos_ptr <= tos_ptr+1 mod DEPTH; mem[tos_ptr+1] <= data.
  - count <= min(count+1, DEPTH).
  - When full, the oldest entry is overwritten (wrap-around); count stays at DEPTH.
- pop only:
  - count > 0: tos_ptr <= tos_ptr-1 mod DEPTH; count <= count-1; mem unchanged.
  - count == 0: no change; top stays 0.
- push and pop together:
  - count > 0: mem[tos_ptr] <= data (replace top); tos_ptr and count unchanged.
  - count == 0: behaves as push only.
- top is forced to 0 when count == 0, even though stale non-zero mem contents may remain.
- A pushed value of 0 is stored, but the consumer treats it as "not available". This is accepted behaviour, not an error.
- restore_count > DEPTH is illegal. Behaviour is unspecified; the assertion fires in simulation only.
- Optional debug: when RAS_PRINT is defined, $display ptr/count/top each cycle.

Decomposition:
- Shared package ras_pkg: RAS_DEPTH (8), RAS_WIDTH (32), RAS_PTR_W (3), RAS_NULL_ADDR (32'h0).
- The predictor and the checkpoint logic both import ras_pkg so pointer widths match.
- Single flat module, no sub-module; the storage array is small enough to be inline flops with async reset.

Test Plan:
- Reset then push 0x00400010, 0x00400020 -> top = 0x00400020, count = 2; pop -> top = 0x00400010, count = 1; pop -> top = 0, empty = 1.
- Push 9 values 0x100..0x900 with DEPTH = 8 -> full = 1, count = 8, top = 0x900; 8 pops return 0x900 down to 0x200 (0x100 lost); a 9th pop leaves count = 0, top = 0.
- With count = 3 and top = 0x30, assert push and pop with data = 0x44 -> top = 0x44, count = 3, tos_ptr unchanged; on an empty stack the same stimulus -> count = 1, top = 0x44.
- With stall = 1, apply push data = 0x55 and separately pop -> tos_ptr, count and top unchanged; with stall = 1 and flush = 1 -> restore takes effect.
- Checkpoint (ptr = 1, count = 2, top = 0x20); push 0xA0, pop, pop; then flush with restore_ptr = 1, restore_count = 2 -> top = 0x20, count = 2, in the cycle after flush.
- Assert reset asynchronously mid-clock while count = 5 -> empty = 1 and top = 0 before the next edge; the first push after release lands at index 0.

Source files
------------

// File: rtl/ras_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ras_pkg
// Description : Shared sizing constants and command encoding for the
//               return-address stack. Imported by the storage stage, the
//               predictor and the checkpoint logic so pointer widths agree.
// Revision    : 1.0 - initial release
// ============================================================================
package ras_pkg;

  localparam int RAS_DEPTH = 8;
  localparam int RAS_WIDTH = 32;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);

  // Value presented on top when no entry is available.
  localparam logic [31:0] RAS_NULL_ADDR = 32'h0;

  // One command is applied per clock edge; this is the resolved command
  // after flush/stall priority and the empty-stack special cases.
  typedef enum logic [2:0] {
    RAS_OP_HOLD    = 3'd0,
    RAS_OP_PUSH    = 3'd1,
    RAS_OP_POP     = 3'd2,
    RAS_OP_REPLACE = 3'd3,
    RAS_OP_RESTORE = 3'd4
  } ras_op_e;

  // Priority: flush beats stall beats push/pop. Push+pop on a non-empty
  // stack overwrites the top in place; on an empty stack it is a plain push.
  // A pop on an empty stack has nothing to discard and is dropped.
  function automatic ras_op_e ras_decode(
    input logic flush,
    input logic stall,
    input logic push,
    input logic pop,
    input logic empty
  );
    ras_op_e op;
    if (flush) begin
      op = RAS_OP_RESTORE;
    end else if (stall) begin
      op = RAS_OP_HOLD;
    end else if (push && pop && !empty) begin
      op = RAS_OP_REPLACE;
    end else if (push) begin
      op = RAS_OP_PUSH;
    end else if (pop && !empty) begin
      op = RAS_OP_POP;
    end else begin
      op = RAS_OP_HOLD;
    end
    return op;
  endfunction

endpackage : ras_pkg
`default_nettype wire

// File: rtl/ras_circular_stack.sv
`default_nettype none
// ============================================================================
// Module      : ras_circular_stack
// Description : Circular LIFO of return addresses feeding the RAS predictor.
//               Overflow overwrites the oldest entry, pointer/occupancy can be
//               restored from a checkpoint on flush, and top reads as zero
//               whenever the stack is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_circular_stack
  import ras_pkg::*;
#(
  parameter  int DEPTH = RAS_DEPTH,
  parameter  int WIDTH = RAS_WIDTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  input  logic             flush,
  input  logic [PTR_W-1:0] restore_ptr,
  input  logic [PTR_W:0]   restore_count,
  output logic [WIDTH-1:0] top,
  output logic [PTR_W-1:0] tos_ptr,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full
);

  localparam logic [PTR_W:0]   C_FULL_COUNT = (PTR_W + 1)'(DEPTH);
  // Reset pointer sits one below slot 0 so the first push lands at index 0.
  localparam logic [PTR_W-1:0] C_RESET_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [WIDTH-1:0] C_NULL       = WIDTH'(RAS_NULL_ADDR);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_tos_ptr;
  logic [PTR_W:0]   r_count;

  logic [PTR_W-1:0] w_ptr_inc;
  logic [PTR_W-1:0] w_ptr_dec;
  logic [PTR_W-1:0] w_tos_ptr_nxt;
  logic [PTR_W:0]   w_count_nxt;
  logic             w_empty;
  logic             w_full;
  logic             w_wr_en;
  logic [PTR_W-1:0] w_wr_idx;
  ras_op_e          w_op;

  // DEPTH is a power of two, so natural pointer wrap gives modulo-DEPTH.
  assign w_ptr_inc = r_tos_ptr + 1'b1;
  assign w_ptr_dec = r_tos_ptr - 1'b1;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_FULL_COUNT);

  // Resolve the command for this edge from flush/stall/push/pop.
  always_comb begin
    w_op = ras_decode(flush, stall, push, pop, w_empty);
  end

  // Next pointer, next occupancy and the single write port for this edge.
  always_comb begin
    w_tos_ptr_nxt = r_tos_ptr;
    w_count_nxt   = r_count;
    w_wr_en       = 1'b0;
    w_wr_idx      = r_tos_ptr;
    case (w_op)
      RAS_OP_PUSH: begin
        // When full the new top lands on the oldest slot; occupancy saturates.
        w_tos_ptr_nxt = w_ptr_inc;
        w_count_nxt   = w_full ? r_count : r_count + 1'b1;
        w_wr_en       = 1'b1;
        w_wr_idx      = w_ptr_inc;
      end
      RAS_OP_POP: begin
        w_tos_ptr_nxt = w_ptr_dec;
        w_count_nxt   = r_count - 1'b1;
      end
      RAS_OP_REPLACE: begin
        w_wr_en  = 1'b1;
        w_wr_idx = r_tos_ptr;
      end
      RAS_OP_RESTORE: begin
        // Only pointer state is rolled back; entries written on the wrong
        // path may remain but are outside the restored window or reused.
        w_tos_ptr_nxt = restore_ptr;
        w_count_nxt   = restore_count;
      end
      default: begin
      end
    endcase
  end

  // Pointer and occupancy registers, cleared immediately on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tos_ptr <= C_RESET_PTR;
      r_count   <= '0;
    end else begin
      r_tos_ptr <= w_tos_ptr_nxt;
      r_count   <= w_count_nxt;
    end
  end

  // Storage entries: one flop row per slot so each clears asynchronously.
  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    // Capture data into this slot when it is the write target.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_mem[i] <= '0;
      end else if (w_wr_en && (w_wr_idx == PTR_W'(i))) begin
        r_mem[i] <= data;
      end
    end
  end : g_mem

  // Stale contents can remain after pops, so an empty stack reads as null.
  assign top     = w_empty ? C_NULL : r_mem[r_tos_ptr];
  assign tos_ptr = r_tos_ptr;
  assign count   = r_count;
  assign empty   = w_empty;
  assign full    = w_full;

`ifndef SYNTHESIS
  // A checkpoint can never hold more entries than the stack has slots.
  a_restore_count_legal : assert property (
    @(posedge clk) disable iff (!reset) flush |-> (restore_count <= C_FULL_COUNT)
  );
`endif

endmodule : ras_circular_stack
`default_nettype wire

// File: tb/tb_ras_circular_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_ras_circular_stack
// Description : Directed self-checking bench for ras_circular_stack (DEPTH 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ras_circular_stack;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
  localparam int PTR_W = 3;

  logic             clk;
  logic             reset;
  logic             stall;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data;
  logic             flush;
  logic [PTR_W-1:0] restore_ptr;
  logic [PTR_W:0]   restore_count;
  logic [WIDTH-1:0] top;
  logic [PTR_W-1:0] tos_ptr;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;

  int checks;
  int errors;

  ras_circular_stack #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .push         (push),
    .pop          (pop),
    .data         (data),
    .flush        (flush),
    .restore_ptr  (restore_ptr),
    .restore_count(restore_count),
    .top          (top),
    .tos_ptr      (tos_ptr),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs are applied at a falling edge, one rising edge passes, and the
  // bench returns at the next falling edge with all commands deasserted.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    stall = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0;
    data = '0; restore_ptr = '0; restore_count = '0;
  endtask

  task automatic do_push(input logic [31:0] d);
    push = 1'b1; data = d; tick();
  endtask

  task automatic do_pop();
    pop = 1'b1; tick();
  endtask

  task automatic do_push_pop(input logic [31:0] d);
    push = 1'b1; pop = 1'b1; data = d; tick();
  endtask

  task automatic do_flush(input logic [PTR_W-1:0] p, input logic [PTR_W:0] c);
    flush = 1'b1; restore_ptr = p; restore_count = c; tick();
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; stall = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0;
    data = '0; restore_ptr = '0; restore_count = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_top",   top,            32'h0);
    check("rst_empty", 32'(empty),     32'd1);
    check("rst_full",  32'(full),      32'd0);
    check("rst_count", 32'(count),     32'd0);
    check("rst_ptr",   32'(tos_ptr),   32'd7);
    reset = 1'b1;
    tick();

    // Basic push / pop
    do_push(32'h0040_0010);
    do_push(32'h0040_0020);
    check("pp_top2",   top,        32'h0040_0020);
    check("pp_cnt2",   32'(count), 32'd2);
    do_pop();
    check("pp_top1",   top,        32'h0040_0010);
    check("pp_cnt1",   32'(count), 32'd1);
    do_pop();
    check("pp_top0",   top,        32'h0);
    check("pp_empty",  32'(empty), 32'd1);

    // Overflow: nine pushes into eight slots, oldest (0x100) is lost
    for (int i = 1; i <= 9; i++) do_push(32'(i * 32'h100));
    check("ov_full",   32'(full),    32'd1);
    check("ov_count",  32'(count),   32'd8);
    check("ov_top",    top,          32'h900);
    check("ov_ptr",    32'(tos_ptr), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ov_pop%0d", i), top, 32'((9 - i) * 32'h100));
      do_pop();
    end
    check("ov_drained_cnt", 32'(count), 32'd0);
    check("ov_drained_top", top,        32'h0);
    do_pop();
    check("ov_xpop_cnt", 32'(count),   32'd0);
    check("ov_xpop_top", top,          32'h0);
    check("ov_xpop_ptr", 32'(tos_ptr), 32'd0);

    // Push+pop replaces the top in place
    do_push(32'h10);
    do_push(32'h20);
    do_push(32'h30);
    check("rp_pre_top", top,          32'h30);
    check("rp_pre_ptr", 32'(tos_ptr), 32'd3);
    do_push_pop(32'h44);
    check("rp_top",   top,          32'h44);
    check("rp_count", 32'(count),   32'd3);
    check("rp_ptr",   32'(tos_ptr), 32'd3);
    repeat (3) do_pop();
    check("rp_emptied", 32'(empty), 32'd1);
    do_push_pop(32'h44);
    check("rp_e_count", 32'(count),   32'd1);
    check("rp_e_top",   top,          32'h44);
    check("rp_e_ptr",   32'(tos_ptr), 32'd1);

    // Stall blocks push and pop; flush overrides stall
    stall = 1'b1; push = 1'b1; data = 32'h55; tick();
    check("st_push_ptr", 32'(tos_ptr), 32'd1);
    check("st_push_cnt", 32'(count),   32'd1);
    check("st_push_top", top,          32'h44);
    stall = 1'b1; pop = 1'b1; tick();
    check("st_pop_ptr",  32'(tos_ptr), 32'd1);
    check("st_pop_cnt",  32'(count),   32'd1);
    check("st_pop_top",  top,          32'h44);
    stall = 1'b1; flush = 1'b1; restore_ptr = 3'd2; restore_count = 4'd2; tick();
    check("st_fl_ptr",   32'(tos_ptr), 32'd2);
    check("st_fl_cnt",   32'(count),   32'd2);
    check("st_fl_top",   top,          32'h20);

    // Checkpoint restore undoes wrong-path push/pop
    reset = 1'b0; #1; reset = 1'b1;
    do_push(32'h10);
    do_push(32'h20);
    check("ck_ptr", 32'(tos_ptr), 32'd1);
    check("ck_cnt", 32'(count),   32'd2);
    check("ck_top", top,          32'h20);
    do_push(32'hA0);
    do_pop();
    do_pop();
    check("ck_wrong_top", top, 32'h10);
    push = 1'b1; data = 32'hBB;
    do_flush(3'd1, 4'd2);
    check("ck_rs_top", top,          32'h20);
    check("ck_rs_cnt", 32'(count),   32'd2);
    check("ck_rs_ptr", 32'(tos_ptr), 32'd1);

    // Asynchronous reset in the middle of a clock-high phase
    do_push(32'h30);
    do_push(32'h40);
    do_push(32'h50);
    check("ar_pre_cnt", 32'(count), 32'd5);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("ar_empty", 32'(empty),   32'd1);
    check("ar_top",   top,          32'h0);
    check("ar_cnt",   32'(count),   32'd0);
    check("ar_ptr",   32'(tos_ptr), 32'd7);
    @(negedge clk);
    reset = 1'b1;
    do_push(32'h77);
    check("ar_first_ptr", 32'(tos_ptr), 32'd0);
    check("ar_first_top", top,          32'h77);
    // Slot 3 held 0x40 before reset; it must read back cleared
    do_flush(3'd3, 4'd1);
    check("ar_mem_clr", top, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_ras_circular_stack
`default_nettype wire
